multi_clock_divider: RTL and testbench

//  Parametrised N-channel integer clock divider for the audio datapath (mic bit clock, sample strobe, etc.).

---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_channel.sv | 69 ++++++
 rtl/multi_clock_divider.sv | 55 +++++
 tb/tb_multi_clock_divider.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;
  localparam int MIN_DIV   = 2;
  localparam int DEF_CNT_W = 16;

  // Odd divisors put the extra cycle in the low phase.
  function automatic int unsigned low_len(input int unsigned div);
    return div - (div >> 1);
  endfunction

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, active/pending divisor, registered clock and edge ticks.
module clk_div_channel import clk_div_pkg::*; #(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = 100
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clk_out,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic             ready
);
  logic [CNT_W-1:0] cnt_d, cnt_q, div_d, div_q, pend_d, pend_q, lo_d;
  logic             pend_vld_d, pend_vld_q;
  logic             clk_d, clk_q, rise_d, rise_q, fall_d, fall_q;
  logic             wrap;

  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    wrap       = enable && (cnt_q == div_q - CNT_W'(1));
    if (!enable || wrap) cnt_d = '0;
    else                 cnt_d = cnt_q + CNT_W'(1);
    // Divisor swaps only at a period boundary, or at once while idle.
    if (pend_vld_q && (!enable || wrap)) begin
      div_d      = pend_q;
      pend_vld_d = 1'b0;
    end
    if (wr) begin
      pend_d     = wr_div;
      pend_vld_d = 1'b1;
    end
    // Outputs are computed from the next state so they line up with the visible counter.
    lo_d   = CNT_W'(low_len(32'(div_d)));
    clk_d  = enable && (cnt_d >= lo_d);
    rise_d = enable && (cnt_d == lo_d);
    fall_d = wrap;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      div_q      <= CNT_W'(DEFAULT_DIV);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_q      <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_q      <= clk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  assign clk_out   = clk_q;
  assign tick_rise = rise_q;
  assign tick_fall = fall_q;
  assign ready     = !pend_vld_q;
endmodule

// File: rtl/multi_clock_divider.sv
// N-channel integer clock divider with a shared, boundary-synchronised divisor config port.
module multi_clock_divider import clk_div_pkg::*; #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = 100
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        cfg_wr,
  input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]            cfg_div,
  output logic [NUM_CH-1:0]           cfg_ready,
  output logic                        cfg_err,
  output logic [NUM_CH-1:0]           clk_out,
  output logic [NUM_CH-1:0]           tick_rise,
  output logic [NUM_CH-1:0]           tick_fall
);
  localparam int CH_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] sel, wr;
  logic              sel_ready, too_small, err_d, err_q;
  logic [CNT_W-1:0]  div_clamp;

  // An out-of-range cfg_ch matches no channel, so sel_ready is 0 and the write is rejected.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) sel[i] = (cfg_ch == CH_W'(i));
    sel_ready = |(sel & cfg_ready);
    too_small = cfg_div < CNT_W'(MIN_DIV);
    div_clamp = too_small ? CNT_W'(MIN_DIV) : cfg_div;
    wr        = (cfg_wr && sel_ready) ? sel : '0;
    err_d     = cfg_wr && (!sel_ready || too_small);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign cfg_err = err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .wr        (wr[g]),
      .wr_div    (div_clamp),
      .clk_out   (clk_out[g]),
      .tick_rise (tick_rise[g]),
      .tick_fall (tick_fall[g]),
      .ready     (cfg_ready[g])
    );
  end
endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed and random bench for multi_clock_divider against a period-position reference model.
module tb_multi_clock_divider;
  localparam int NCH  = 3;
  localparam int CW   = 16;
  localparam int DDIV = 100;

  logic            clock = 1'b0;
  logic            reset, enable, cfg_wr;
  logic [1:0]      cfg_ch;
  logic [CW-1:0]   cfg_div;
  logic [NCH-1:0]  cfg_ready, clk_out, tick_rise, tick_fall;
  logic            cfg_err;

  multi_clock_divider #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DDIV)) dut (
    .clock(clock), .reset(reset), .enable(enable), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clk_out(clk_out),
    .tick_rise(tick_rise), .tick_fall(tick_fall)
  );

  always #5 clock = ~clock;

  int n_asrt = 0, n_fail = 0;

  // Model: position within the current period, active divisor, pending divisor.
  int m_pos[NCH], m_div[NCH], m_pend[NCH];
  bit m_pv[NCH], m_clk[NCH], m_rise[NCH], m_fall[NCH];
  bit m_err;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pos[i] = 0; m_div[i] = DDIV; m_pend[i] = 0;
      m_pv[i] = 0; m_clk[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
    end
    m_err = 0;
  endtask

  task automatic model_edge();
    bit acc; int wv, lo;
    if (reset) begin model_reset(); return; end
    acc = 0; m_err = 0;
    wv = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
    if (cfg_wr) begin
      if (int'(cfg_ch) >= NCH)  m_err = 1;
      else if (m_pv[cfg_ch])    m_err = 1;
      else begin acc = 1; if (int'(cfg_div) < 2) m_err = 1; end
    end
    for (int i = 0; i < NCH; i++) begin
      m_fall[i] = 0;
      if (!enable) begin
        m_pos[i] = 0;
        if (m_pv[i]) begin m_div[i] = m_pend[i]; m_pv[i] = 0; end
      end else if (m_pos[i] + 1 == m_div[i]) begin
        m_pos[i] = 0; m_fall[i] = 1;
        if (m_pv[i]) begin m_div[i] = m_pend[i]; m_pv[i] = 0; end
      end else m_pos[i]++;
      if (acc && int'(cfg_ch) == i) begin m_pend[i] = wv; m_pv[i] = 1; end
      lo = m_div[i] - m_div[i] / 2;
      m_clk[i]  = enable && (m_pos[i] >= lo);
      m_rise[i] = enable && (m_pos[i] == lo);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("clk_out[%0d]", i),   clk_out[i],   m_clk[i]);
      chk($sformatf("tick_rise[%0d]", i), tick_rise[i], m_rise[i]);
      chk($sformatf("tick_fall[%0d]", i), tick_fall[i], m_fall[i]);
      chk($sformatf("cfg_ready[%0d]", i), cfg_ready[i], !m_pv[i]);
    end
    chk("cfg_err", cfg_err, m_err);
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic wr(input int ch, input int div);
    cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_div = CW'(div);
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic wait_ready(input int ch);
    int n = 0;
    while (cfg_ready[ch] !== 1'b1 && n < 300) begin tick(); n++; end
    chk($sformatf("ready_timeout[%0d]", ch), cfg_ready[ch], 1'b1);
  endtask

  initial begin
    int hi, rs, n;
    reset = 1'b1; enable = 1'b1; cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0;
    model_reset();
    #1;
    compare_all();
    tick(); tick();
    reset = 1'b0;

    // 1: default divisor, 50 low then 50 high, one rise per period.
    hi = 0; rs = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      hi += int'(clk_out[0]); rs += int'(tick_rise[0]);
    end
    n_asrt++;
    assert (hi == 50 && rs == 1) else begin
      n_fail++; $error("FAIL default_period got hi=%0d rise=%0d expected hi=50 rise=1", hi, rs);
    end

    // 2: ch0 div 4 then 5; ch1 div 8 mid-period.
    wr(0, 4);
    wait_ready(0);
    for (int k = 0; k < 8; k++) tick();
    wr(0, 5);
    for (int k = 0; k < 20; k++) tick();
    wr(1, 8);
    wait_ready(1);
    for (int k = 0; k < 20; k++) tick();

    // 3: clamp with error, then a rejected write while pending.
    wait_ready(0);
    wr(0, 1);
    chk("clamp_err", cfg_err, 1'b1);
    wr(0, 7);
    chk("busy_err", cfg_err, 1'b1);
    wait_ready(0);
    for (int k = 0; k < 12; k++) tick();

    // 4: equal divisors align after an enable toggle.
    wait_ready(0); wr(0, 6);
    wait_ready(1); wr(1, 6);
    wait_ready(0);
    for (int k = 0; k < 7; k++) tick();
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("idle_clk0", clk_out[0], 1'b0);
    end
    enable = 1'b1;
    tick(); tick(); tick();
    chk("align_rise0", tick_rise[0], 1'b1);
    chk("align_rise1", tick_rise[1], 1'b1);

    // 5: reset while high with a divisor pending.
    n = 0;
    while (tick_rise[0] !== 1'b1 && n < 20) begin tick(); n++; end
    wr(0, 9);
    chk("pre_reset_clk0", clk_out[0], 1'b1);
    chk("pre_reset_ready0", cfg_ready[0], 1'b0);
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < 110; k++) tick();

    // 6: out-of-range channel.
    wr(3, 10);
    chk("range_err", cfg_err, 1'b1);
    for (int k = 0; k < 10; k++) tick();

    // Random writes and enable changes.
    for (int k = 0; k < 1500; k++) begin
      cfg_wr  = ($urandom_range(0, 3) == 0);
      cfg_ch  = 2'($urandom_range(0, 3));
      cfg_div = CW'($urandom_range(0, 12));
      if ($urandom_range(0, 40) == 0) enable = ~enable;
      tick();
    end
    cfg_wr = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
